fb_write_scheduler: RTL and testbench



---
 rtl/fb_write_scheduler_pkg.sv | 16 +
 rtl/fb_write_scheduler_if.sv | 13 +
 rtl/fb_write_scheduler_clear.sv | 39 +++
 rtl/fb_write_scheduler.sv | 143 ++++++++++++++
 tb/tb_fb_write_scheduler.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_write_scheduler_pkg.sv
// Shared state type and default framebuffer geometry for the framebuffer write scheduler.
package fb_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_SCREEN_WIDTH  = 640;
    localparam int DEF_SCREEN_HEIGHT = 480;
    localparam int NUM_WORDS         = DEF_SCREEN_WIDTH * DEF_SCREEN_HEIGHT / DEF_DATA_WIDTH;
    localparam int OFFSET_W          = $clog2(DEF_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Pixel-plot request handshake between the renderer (master) and the write scheduler (slave).
interface fb_pix_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9
);
    logic               pix_valid;
    logic               pix_ready;
    logic [X_WIDTH-1:0] pix_x;
    logic [Y_WIDTH-1:0] pix_y;

    modport master (output pix_valid, output pix_x, output pix_y, input pix_ready);
    modport slave  (input pix_valid, input pix_x, input pix_y, output pix_ready);
endinterface

// File: rtl/fb_write_scheduler_clear.sv
// Frame-clear engine: while active, sweeps word addresses 0..NUM_WORDS-1 with zero data
// and pulses clear_done the cycle after the last word.
module fb_clear_engine #(
    parameter int ADDRESS_LENGTH = 14,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WORDS      = 9600
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      active,
    output logic [ADDRESS_LENGTH-1:0] clr_addr,
    output logic [DATA_WIDTH-1:0]     clr_wdata,
    output logic                      clr_we,
    output logic                      clr_last,
    output logic                      clear_done
);

    logic [ADDRESS_LENGTH-1:0] count;

    assign clr_last  = (count == ADDRESS_LENGTH'(NUM_WORDS - 1));
    assign clr_addr  = count;
    assign clr_wdata = '0;
    assign clr_we    = active;

    // Counter parks at 0 whenever idle so every sweep starts from word 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count      <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= active && clr_last;
            if (!active || clr_last)
                count <= '0;
            else
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: plot sequencing to the RMW pixel writer, frame-clear arbitration
// and framebuffer port mux. Define FB_BOUNDS_CHECK_EN to drop off-screen plots and flag oob_error.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDRESS_LENGTH = 14,
    parameter int SCREEN_WIDTH   = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT  = DEF_SCREEN_HEIGHT,
    parameter int X_WIDTH        = 10,
    parameter int Y_WIDTH        = 9,
    parameter int WRITER_LATENCY = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    fb_pix_if.slave                       pix,
    input  logic                          clear_start,
    output logic                          clear_done,
    output logic                          busy,
    output logic [ADDRESS_LENGTH-1:0]     word_address,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_offset,
    output logic                          word_and_offset_valid,
    input  logic [ADDRESS_LENGTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_we,
    output logic [ADDRESS_LENGTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          mem_we
`ifdef FB_BOUNDS_CHECK_EN
    ,
    input  logic                          oob_clear,
    output logic                          oob_error
`endif
);

    localparam int OFF_W   = $clog2(DATA_WIDTH);
    localparam int LIN_W   = X_WIDTH + Y_WIDTH + $clog2(SCREEN_WIDTH);
    localparam int N_WORDS = SCREEN_WIDTH * SCREEN_HEIGHT / DATA_WIDTH;
    localparam int WAIT_W  = $clog2(WRITER_LATENCY + 2);

    fb_state_e                 state;
    logic                      clear_pending;
    logic [WAIT_W-1:0]         wait_cnt;
    logic [LIN_W-1:0]          lin;
    logic                      accept;
    logic                      oob;
    logic [ADDRESS_LENGTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0]     clr_wdata;
    logic                      clr_we;
    logic                      clr_last;

    assign pix.pix_ready = (state == IDLE) && !clear_pending && !clear_start;
    assign accept        = pix.pix_valid && pix.pix_ready;
    assign busy          = (state != IDLE);
    assign lin           = LIN_W'(pix.pix_y) * LIN_W'(SCREEN_WIDTH) + LIN_W'(pix.pix_x);

`ifdef FB_BOUNDS_CHECK_EN
    assign oob = (int'(pix.pix_x) >= SCREEN_WIDTH) || (int'(pix.pix_y) >= SCREEN_HEIGHT);

    // Set has priority over clear when both land in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            oob_error <= 1'b0;
        else if (accept && oob)
            oob_error <= 1'b1;
        else if (oob_clear)
            oob_error <= 1'b0;
    end
`else
    assign oob = 1'b0;
`endif

    // state | meaning
    // IDLE  | ready for a plot request, or about to start a pending clear
    // WAIT  | writer RMW in flight; address/offset held, WRITER_LATENCY+1 cycles
    // CLEAR | clear engine owns the framebuffer port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state                 <= IDLE;
            clear_pending         <= 1'b0;
            wait_cnt              <= '0;
            word_address          <= '0;
            bit_offset            <= '0;
            word_and_offset_valid <= 1'b0;
        end else begin
            word_and_offset_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start || clear_pending) begin
                        state         <= CLEAR;
                        clear_pending <= 1'b0;
                    end else if (accept && !oob) begin
                        word_address          <= ADDRESS_LENGTH'(lin >> OFF_W);
                        bit_offset            <= pix.pix_x[OFF_W-1:0];
                        word_and_offset_valid <= 1'b1;
                        wait_cnt              <= WAIT_W'(WRITER_LATENCY);
                        state                 <= WAIT;
                    end
                end
                WAIT: begin
                    if (clear_start)
                        clear_pending <= 1'b1;
                    if (wait_cnt == '0)
                        state <= IDLE;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                CLEAR: begin
                    if (clr_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fb_clear_engine #(
        .ADDRESS_LENGTH (ADDRESS_LENGTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_WORDS      (N_WORDS)
    ) u_clear (
        .clk        (clk),
        .resetn     (resetn),
        .active     (state == CLEAR),
        .clr_addr   (clr_addr),
        .clr_wdata  (clr_wdata),
        .clr_we     (clr_we),
        .clr_last   (clr_last),
        .clear_done (clear_done)
    );

    always_comb begin
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_we    = wr_we;
        if (state == CLEAR) begin
            mem_addr  = clr_addr;
            mem_wdata = clr_wdata;
            mem_we    = clr_we;
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: table of plot vectors plus hand-written clear,
// contention and reset sequences. Covers the oob path when FB_BOUNDS_CHECK_EN is defined.
module tb_fb_write_scheduler;
    import fb_pkg::*;

    localparam int AW = 14;
    localparam int DW = 32;
    localparam int XW = 10;
    localparam int YW = 9;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fb_pix_if #(.X_WIDTH(XW), .Y_WIDTH(YW)) pif ();

    logic          clear_start;
    logic          clear_done;
    logic          busy;
    logic [AW-1:0] word_address;
    logic [4:0]    bit_offset;
    logic          wov;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
`ifdef FB_BOUNDS_CHECK_EN
    logic          oob_clear;
    logic          oob_error;
`endif

    fb_write_scheduler dut (
        .clk                   (clk),
        .resetn                (resetn),
        .pix                   (pif),
        .clear_start           (clear_start),
        .clear_done            (clear_done),
        .busy                  (busy),
        .word_address          (word_address),
        .bit_offset            (bit_offset),
        .word_and_offset_valid (wov),
        .wr_addr               (wr_addr),
        .wr_data               (wr_data),
        .wr_we                 (wr_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .mem_we                (mem_we)
`ifdef FB_BOUNDS_CHECK_EN
        ,
        .oob_clear             (oob_clear),
        .oob_error             (oob_error)
`endif
    );

    typedef struct {
        int x;
        int y;
        int word;
        int off;
    } plot_vec_t;

    plot_vec_t tbl[7];
    int vecs = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Waits for clear_done with a cycle budget; returns whether it was seen.
    task automatic wait_clear_done(input int budget, output bit seen, output bit plot_seen);
        seen = 1'b0;
        plot_seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (wov === 1'b1) plot_seen = 1'b1;
            if (clear_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic plot_and_check(input int x, input int y, input int w, input int o, input string tag);
        pif.pix_x     = XW'(x);
        pif.pix_y     = YW'(y);
        pif.pix_valid = 1'b1;
        #1;
        chk({tag, ".ready_idle"}, pif.pix_ready, 1);
        tick();
        pif.pix_valid = 1'b0;
        chk({tag, ".valid"}, wov, 1);
        chk({tag, ".word"}, word_address, w);
        chk({tag, ".offset"}, bit_offset, o);
        chk({tag, ".busy"}, busy, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                tick();
                chk({tag, ".valid_drop"}, wov, 0);
                chk({tag, ".word_hold"}, word_address, w);
            end
            chk({tag, ".ready_wait"}, pif.pix_ready, 0);
            if (k == 2) begin
                wr_addr = AW'(w);
                wr_data = 32'hC0DE0000 ^ DW'(w);
                wr_we   = 1'b1;
                #1;
                chk({tag, ".mem_we_pass"}, mem_we, 1);
                chk({tag, ".mem_addr_pass"}, mem_addr, w);
                chk({tag, ".mem_wdata_pass"}, mem_wdata, 32'hC0DE0000 ^ w);
                wr_we   = 1'b0;
                wr_addr = '0;
                wr_data = '0;
            end
        end
        tick();
        chk({tag, ".ready_again"}, pif.pix_ready, 1);
        chk({tag, ".idle_again"}, busy, 0);
    endtask

    initial begin
        bit seen;
        bit plot_seen;
        int bad;

        tbl[0] = '{33, 0, 1, 1};
        tbl[1] = '{639, 479, 9599, 31};
        tbl[2] = '{0, 0, 0, 0};
        tbl[3] = '{31, 1, 20, 31};
        tbl[4] = '{100, 10, 203, 4};
        tbl[5] = '{320, 240, 4810, 0};
        tbl[6] = '{5, 200, 4000, 5};

        pif.pix_valid = 1'b0;
        pif.pix_x     = '0;
        pif.pix_y     = '0;
        clear_start   = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        wr_we         = 1'b0;
`ifdef FB_BOUNDS_CHECK_EN
        oob_clear     = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #2;
        chk("rst.valid", wov, 0);
        chk("rst.word", word_address, 0);
        chk("rst.offset", bit_offset, 0);
        chk("rst.busy", busy, 0);
        chk("rst.clear_done", clear_done, 0);
        chk("rst.mem_we", mem_we, 0);
        resetn = 1'b1;
        tick();
        chk("rst.ready_after", pif.pix_ready, 1);

        for (int i = 0; i < 7; i++)
            plot_and_check(tbl[i].x, tbl[i].y, tbl[i].word, tbl[i].off, $sformatf("plot%0d", i));

        // Full clear from IDLE; a second clear_start mid-sweep must be ignored.
        clear_start = 1'b1;
        #1;
        chk("clr.ready_blocked", pif.pix_ready, 0);
        tick();
        clear_start = 1'b0;
        bad = 0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (i > 0) tick();
            clear_start = (i == 50);
            if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== '0 ||
                clear_done !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        clear_start = 1'b0;
        chk("clr.sweep_errors", bad, 0);
        tick();
        chk("clr.done_pulse", clear_done, 1);
        chk("clr.busy_after", busy, 0);
        chk("clr.ready_after", pif.pix_ready, 1);
        tick();
        chk("clr.done_drop", clear_done, 0);
        chk("clr.no_restart", busy, 0);

        // clear_start two cycles after a plot accept: plot completes, then clear runs.
        pif.pix_x = 10'd33; pif.pix_y = 9'd0; pif.pix_valid = 1'b1;
        #1;
        tick();
        pif.pix_valid = 1'b0;
        chk("ct1.valid", wov, 1);
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("ct1.still_wait", busy, 1);
        chk("ct1.word_hold", word_address, 1);
        chk("ct1.ready", pif.pix_ready, 0);
        tick(); tick(); tick();
        chk("ct1.plot_done", busy, 0);
        chk("ct1.pending_blocks", pif.pix_ready, 0);
        tick();
        chk("ct1.clear_we", mem_we, 1);
        chk("ct1.clear_addr0", mem_addr, 0);
        wait_clear_done(12000, seen, plot_seen);
        chk("ct1.clear_done", seen, 1);
        chk("ct1.busy_after", busy, 0);

        // Simultaneous clear_start and pix_valid: clear first, pixel held and taken after.
        tick();
        clear_start = 1'b1;
        pif.pix_x = 10'd100; pif.pix_y = 9'd10; pif.pix_valid = 1'b1;
        #1;
        chk("ct2.ready_low", pif.pix_ready, 0);
        tick();
        clear_start = 1'b0;
        chk("ct2.in_clear", mem_we, 1);
        wait_clear_done(12000, seen, plot_seen);
        chk("ct2.clear_done", seen, 1);
        chk("ct2.no_plot_during_clear", plot_seen, 0);
        chk("ct2.ready_after", pif.pix_ready, 1);
        tick();
        pif.pix_valid = 1'b0;
        chk("ct2.valid", wov, 1);
        chk("ct2.word", word_address, 203);
        chk("ct2.offset", bit_offset, 4);
        repeat (5) tick();
        chk("ct2.idle", busy, 0);

        // Reset asserted at clear word 100.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("rmc.at_word100", mem_addr, 100);
        resetn = 1'b0;
        #1;
        chk("rmc.mem_we", mem_we, 0);
        chk("rmc.busy", busy, 0);
        chk("rmc.mem_addr", mem_addr, 0);
        chk("rmc.clear_done", clear_done, 0);
        tick(); tick();
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clear_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("rmc.no_done_after", bad, 0);
        chk("rmc.ready", pif.pix_ready, 1);

`ifdef FB_BOUNDS_CHECK_EN
        pif.pix_x = 10'd640; pif.pix_y = 9'd0; pif.pix_valid = 1'b1;
        #1;
        chk("oob.ready", pif.pix_ready, 1);
        tick();
        pif.pix_valid = 1'b0;
        chk("oob.no_valid", wov, 0);
        chk("oob.idle", busy, 0);
        chk("oob.err_set", oob_error, 1);
        tick();
        chk("oob.sticky", oob_error, 1);
        oob_clear = 1'b1;
        tick();
        oob_clear = 1'b0;
        chk("oob.cleared", oob_error, 0);
`else
        plot_and_check(640, 0, 20, 0, "nochk");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
